score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
Game-state and scoring engine that sits directly upstream of the on-screen score digit renderer.
- Consumes asteroid-hit and ship-collision events from the collision logic.
- Accumulates an 8-bit binary score, tracks lives and a high score, and sequences play, respawn and game-over.
- The score output drives the renderer's binary score input unchanged.
- The high_score output can feed a second renderer instance.

Parameters:
PTS_LARGE, 1, points for a large asteroid (hit_size 2'b00)
PTS_MED, 2, points for a medium asteroid (hit_size 2'b01)
PTS_SMALL, 5, points for a small asteroid (hit_size 2'b10)
START_LIVES, 3, lives loaded at game start; range 1..3
RESPAWN_FRAMES, 120, number of frame_tick pulses spent in RESPAWN
BONUS_STEP, 50, score interval that awards a bonus life (only used with BONUS_LIFE_EN)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset, asynchronous, active-high
frame_tick  in  1  one-clk pulse per video frame (start of vblank)
start  in  1  one-clk pulse from the debounced start button
hit_valid  in  1  one-clk pulse: an asteroid was destroyed this cycle
hit_size  in  2  asteroid size, qualified by hit_valid; 2'b11 is reserved
ship_hit  in  1  one-clk pulse: the ship collided with an asteroid
score  out  8  current score, binary, 0..255
high_score  out  8  best score since rst, binary
lives  out  2  remaining lives, 0..3
playing  out  1  high in the PLAY state
respawning  out  1  high in the RESPAWN state
game_over  out  1  high in the OVER state

Behaviour:
- Reset is asynchronous, active-high on rst, with clock clk. Reset values:
  - state = IDLE
  - score = 0, high_score = 0, lives = 0
  - playing = 0, respawning = 0, game_over = 0
  - respawn counter = 0, bonus threshold = BONUS_STEP
- All outputs are registered. Every effect lands on the clk edge after the triggering input cycle (1-cycle latency).
- State IDLE:
  - start loads score = 0 and lives = START_LIVES, then goes to PLAY.
  - All other inputs are ignored.
- State PLAY, scoring:
  - On hit_valid, score = min(score + points(hit_size), 255).
  - The add is 9 bits wide and saturates at 255; the score never wraps.
  - hit_size 2'b11 adds 0 points.
- State PLAY, ship_hit:
  - If lives > 1: lives decrements, respawn counter loads RESPAWN_FRAMES, go to RESPAWN.
  - If lives == 1: lives becomes 0, go to OVER.
- Same-cycle hit_valid and ship_hit in PLAY: the points are added AND the ship_hit transition is taken in the same edge.
- State RESPAWN:
  - Each frame_tick decrements the counter.
  - When the tick arrives with counter == 1, go to PLAY.
  - hit_valid and ship_hit are ignored; score is frozen.
  - RESPAWN_FRAMES = 0 is treated as 1.
- Entering OVER:
  - If score > high_score, high_score takes score on the same edge.
  - If the scores are equal, high_score is unchanged.
- State OVER:
  - start clears score to 0, loads lives = START_LIVES and goes to PLAY.
  - The previous score stays visible until start.
- start is ignored in PLAY and RESPAWN.
- frame_tick has no effect outside RESPAWN.
- Exactly one of playing, respawning or game_over is high, except in IDLE, where all three are 0.
- rst asserted in any state, including mid-RESPAWN, forces the reset values immediately. high_score is cleared only by rst.

Optional Feature:
BONUS_LIFE_EN.
- Defined:
  - When a scoring add makes score cross or reach the bonus threshold, lives increments, saturating at 3. The threshold then advances by BONUS_STEP, saturating at 255; once it saturates, no further bonuses are awarded.
  - At most one bonus is awarded per hit.
  - Each game start resets the threshold to BONUS_STEP.
  - If a bonus and a ship_hit land in the same cycle, the net lives change is 0 and the state still goes to RESPAWN. If lives was 1, the bonus cancels the loss: lives stays 1, the state goes to RESPAWN, not OVER.
- Undefined: no bonus logic or threshold register is built, and lives only decrements.

Test Plan:
1. Reset then start -> next edge: playing = 1, lives = 3, score = 0, game_over = 0.
2. Overflow: in PLAY, hit_valid with sizes 00, 01, 10, 11 -> score 1, 3, 8, 8. Then 60 small hits -> score saturates at 255 with no wrap.
3. Respawn timing: ship_hit with lives = 3 -> lives = 2, respawning = 1. hit_valid during RESPAWN -> score unchanged. Exactly 120 frame_ticks later -> playing = 1.
4. Game over and high score: with score = 40, drive lives to 0 -> game_over = 1, high_score = 40. start -> score = 0, lives = 3, high_score = 40. A second game ending at 30 -> high_score stays 40.
5. Simultaneous events: hit_valid (small) and ship_hit in the same cycle with lives = 1 -> score increases by 5, high_score updated, state OVER.
6. Bonus life (BONUS_LIFE_EN defined): score 48 plus a small hit -> score 53, lives increments. The next bonus comes at 100. With the macro undefined, the same stimulus leaves lives unchanged.

Source files
------------

// File: rtl/score_keeper_if.sv
// Event and status bundle between the collision logic and score_keeper.
// The master side drives the game events, the slave side (score_keeper)
// returns the registered score and game state.
interface score_keeper_if;
    logic       frame_tick;
    logic       start;
    logic       hit_valid;
    logic [1:0] hit_size;
    logic       ship_hit;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [1:0] lives;
    logic       playing;
    logic       respawning;
    logic       game_over;

    modport master (
        output frame_tick, start, hit_valid, hit_size, ship_hit,
        input  score, high_score, lives, playing, respawning, game_over
    );

    modport slave (
        input  frame_tick, start, hit_valid, hit_size, ship_hit,
        output score, high_score, lives, playing, respawning, game_over
    );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: game-state and scoring engine feeding the score renderer.
// Optional bonus-life logic is built only when BONUS_LIFE_EN is defined.
//
// state   | meaning
// IDLE    | after reset, waiting for the first start
// PLAY    | ship alive, hits score points
// RESPAWN | ship destroyed, down-counting frame ticks before play resumes
// OVER    | no lives left, last score shown until start
module score_keeper #(
    parameter int PTS_LARGE      = 1,
    parameter int PTS_MED        = 2,
    parameter int PTS_SMALL      = 5,
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_FRAMES = 120,
    parameter int BONUS_STEP     = 50
) (
    input  logic          clk,
    input  logic          rst,
    score_keeper_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_RESPAWN = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    // A zero-length respawn still spends one frame in RESPAWN.
    localparam int CNT_LOAD = (RESPAWN_FRAMES < 1) ? 1 : RESPAWN_FRAMES;
    localparam int CNT_W    = $clog2(CNT_LOAD + 1);

    logic [1:0]       state, state_nxt;
    logic [7:0]       score_r, score_nxt;
    logic [7:0]       high_r, high_nxt;
    logic [1:0]       lives_r, lives_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             playing_r, respawning_r, over_r;
    logic [7:0]       pts;
    logic [8:0]       sum9;
    logic [7:0]       score_add;
    logic             bonus;

`ifdef BONUS_LIFE_EN
    logic [7:0]       thr, thr_nxt;
    logic [8:0]       thr_sum;
    logic [7:0]       thr_adv;
`endif

    // Points for the destroyed asteroid; the reserved size scores nothing.
    always_comb begin
        pts = 8'd0;
        case (bus.hit_size)
            2'b00:   pts = 8'(PTS_LARGE);
            2'b01:   pts = 8'(PTS_MED);
            2'b10:   pts = 8'(PTS_SMALL);
            default: pts = 8'd0;
        endcase
    end

    // 9-bit add so a carry saturates the score instead of wrapping.
    always_comb begin
        sum9      = {1'b0, score_r} + {1'b0, pts};
        score_add = sum9[8] ? 8'hFF : sum9[7:0];
    end

`ifdef BONUS_LIFE_EN
    // Next bonus threshold; pinned at 255 once it overflows, which ends bonuses.
    always_comb begin
        thr_sum = {1'b0, thr} + 9'(BONUS_STEP);
        thr_adv = thr_sum[8] ? 8'hFF : thr_sum[7:0];
        bonus   = (state == ST_PLAY) && bus.hit_valid && (thr != 8'hFF) &&
                  (score_r < thr) && (score_add >= thr);
    end
`else
    // No bonus lives in this build.
    always_comb bonus = 1'b0;
`endif

    // Next-state and next-value logic for the game sequencer.
    always_comb begin
        state_nxt = state;
        score_nxt = score_r;
        high_nxt  = high_r;
        lives_nxt = lives_r;
        cnt_nxt   = cnt;
`ifdef BONUS_LIFE_EN
        thr_nxt   = thr;
`endif
        case (state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    score_nxt = 8'd0;
                    lives_nxt = 2'(START_LIVES);
                    state_nxt = ST_PLAY;
`ifdef BONUS_LIFE_EN
                    thr_nxt   = 8'(BONUS_STEP);
`endif
                end
            end
            ST_PLAY: begin
                if (bus.hit_valid)
                    score_nxt = score_add;
                if (bonus) begin
                    lives_nxt = (lives_r == 2'd3) ? 2'd3 : lives_r + 2'd1;
`ifdef BONUS_LIFE_EN
                    thr_nxt   = thr_adv;
`endif
                end
                if (bus.ship_hit) begin
                    if (bonus) begin
                        // Bonus and loss cancel: lives stay, ship still respawns.
                        lives_nxt = lives_r;
                        cnt_nxt   = CNT_W'(CNT_LOAD);
                        state_nxt = ST_RESPAWN;
                    end else if (lives_r > 2'd1) begin
                        lives_nxt = lives_r - 2'd1;
                        cnt_nxt   = CNT_W'(CNT_LOAD);
                        state_nxt = ST_RESPAWN;
                    end else begin
                        lives_nxt = 2'd0;
                        state_nxt = ST_OVER;
                        if (score_nxt > high_r)
                            high_nxt = score_nxt;
                    end
                end
            end
            ST_RESPAWN: begin
                if (bus.frame_tick) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt <= CNT_W'(1))
                        state_nxt = ST_PLAY;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Register state, counters and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            score_r      <= 8'd0;
            high_r       <= 8'd0;
            lives_r      <= 2'd0;
            cnt          <= '0;
            playing_r    <= 1'b0;
            respawning_r <= 1'b0;
            over_r       <= 1'b0;
`ifdef BONUS_LIFE_EN
            thr          <= 8'(BONUS_STEP);
`endif
        end else begin
            state        <= state_nxt;
            score_r      <= score_nxt;
            high_r       <= high_nxt;
            lives_r      <= lives_nxt;
            cnt          <= cnt_nxt;
            playing_r    <= (state_nxt == ST_PLAY);
            respawning_r <= (state_nxt == ST_RESPAWN);
            over_r       <= (state_nxt == ST_OVER);
`ifdef BONUS_LIFE_EN
            thr          <= thr_nxt;
`endif
        end
    end

    assign bus.score      = score_r;
    assign bus.high_score = high_r;
    assign bus.lives      = lives_r;
    assign bus.playing    = playing_r;
    assign bus.respawning = respawning_r;
    assign bus.game_over  = over_r;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper (default parameters).
module tb_score_keeper;

`ifdef BONUS_LIFE_EN
    localparam bit BON = 1'b1;
`else
    localparam bit BON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    score_keeper_if sk_if ();

    score_keeper dut (
        .clk (clk),
        .rst (rst),
        .bus (sk_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic p, input logic r, input logic o);
        check({tag, ".playing"},    9'(sk_if.playing),    9'(p));
        check({tag, ".respawning"}, 9'(sk_if.respawning), 9'(r));
        check({tag, ".game_over"},  9'(sk_if.game_over),  9'(o));
    endtask

    // Advance one clock; leaves time 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        sk_if.start = 1'b1; step(); sk_if.start = 1'b0;
    endtask

    task automatic do_hit(input logic [1:0] sz);
        sk_if.hit_valid = 1'b1; sk_if.hit_size = sz; step();
        sk_if.hit_valid = 1'b0; sk_if.hit_size = 2'b00;
    endtask

    task automatic do_smalls(input int n);
        for (int i = 0; i < n; i++) do_hit(2'b10);
    endtask

    task automatic do_ship();
        sk_if.ship_hit = 1'b1; step(); sk_if.ship_hit = 1'b0;
    endtask

    // Frame ticks with an idle cycle between each.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sk_if.frame_tick = 1'b1; step(); sk_if.frame_tick = 1'b0; step();
        end
    endtask

    initial begin
        sk_if.frame_tick = 1'b0;
        sk_if.start      = 1'b0;
        sk_if.hit_valid  = 1'b0;
        sk_if.hit_size   = 2'b00;
        sk_if.ship_hit   = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst.score", 9'(sk_if.score), 9'd0);
        check("rst.high",  9'(sk_if.high_score), 9'd0);
        check("rst.lives", 9'(sk_if.lives), 9'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        // IDLE ignores hits and ticks
        do_hit(2'b10);
        sk_if.frame_tick = 1'b1; step(); sk_if.frame_tick = 1'b0;
        check("idle.score", 9'(sk_if.score), 9'd0);
        check_flags("idle", 1'b0, 1'b0, 1'b0);

        // Game A: start
        do_start();
        check_flags("startA", 1'b1, 1'b0, 1'b0);
        check("startA.lives", 9'(sk_if.lives), 9'd3);
        check("startA.score", 9'(sk_if.score), 9'd0);

        do_hit(2'b00); check("A.large",    9'(sk_if.score), 9'd1);
        do_hit(2'b01); check("A.med",      9'(sk_if.score), 9'd3);
        do_hit(2'b10); check("A.small",    9'(sk_if.score), 9'd8);
        do_hit(2'b11); check("A.reserved", 9'(sk_if.score), 9'd8);

        // Respawn timing and frozen play
        do_ship();
        check("A.ship1.lives", 9'(sk_if.lives), 9'd2);
        check_flags("A.ship1", 1'b0, 1'b1, 1'b0);
        do_hit(2'b10);
        check("A.resp.score", 9'(sk_if.score), 9'd8);
        do_ship();
        check("A.resp.lives", 9'(sk_if.lives), 9'd2);
        do_start();
        check_flags("A.resp.start", 1'b0, 1'b1, 1'b0);
        do_ticks(119);
        check_flags("A.tick119", 1'b0, 1'b1, 1'b0);
        do_ticks(1);
        check_flags("A.tick120", 1'b1, 1'b0, 1'b0);
        check("A.tick120.lives", 9'(sk_if.lives), 9'd2);

        // Game over at 40
        do_smalls(6);
        do_hit(2'b01);
        check("A.score40", 9'(sk_if.score), 9'd40);
        do_ship();
        do_ticks(120);
        check("A.lives1", 9'(sk_if.lives), 9'd1);
        do_ship();
        check_flags("A.over", 1'b0, 1'b0, 1'b1);
        check("A.over.lives", 9'(sk_if.lives), 9'd0);
        check("A.over.high",  9'(sk_if.high_score), 9'd40);
        check("A.over.score", 9'(sk_if.score), 9'd40);
        do_hit(2'b10);
        do_ticks(2);
        check("A.over.frozen", 9'(sk_if.score), 9'd40);
        check_flags("A.over.hold", 1'b0, 1'b0, 1'b1);

        // Game B ends at 30; high score stays 40
        do_start();
        check("B.start.score", 9'(sk_if.score), 9'd0);
        check("B.start.lives", 9'(sk_if.lives), 9'd3);
        check("B.start.high",  9'(sk_if.high_score), 9'd40);
        do_smalls(6);
        do_ship(); do_ticks(120);
        do_ship(); do_ticks(120);
        do_ship();
        check_flags("B.over", 1'b0, 1'b0, 1'b1);
        check("B.over.score", 9'(sk_if.score), 9'd30);
        check("B.over.high",  9'(sk_if.high_score), 9'd40);

        // Game C: simultaneous hit and ship_hit on the last life
        do_start();
        do_smalls(8);
        do_hit(2'b01);
        do_hit(2'b00);
        check("C.score43", 9'(sk_if.score), 9'd43);
        do_ship(); do_ticks(120);
        do_ship(); do_ticks(120);
        check("C.lives1", 9'(sk_if.lives), 9'd1);
        sk_if.hit_valid = 1'b1; sk_if.hit_size = 2'b10; sk_if.ship_hit = 1'b1;
        step();
        sk_if.hit_valid = 1'b0; sk_if.hit_size = 2'b00; sk_if.ship_hit = 1'b0;
        check("C.sim.score", 9'(sk_if.score), 9'd48);
        check("C.sim.high",  9'(sk_if.high_score), 9'd48);
        check("C.sim.lives", 9'(sk_if.lives), 9'd0);
        check_flags("C.sim", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a respawn
        do_start();
        do_ship();
        do_ticks(60);
        check_flags("R.mid", 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #2;
        check("R.async.high",  9'(sk_if.high_score), 9'd0);
        check("R.async.lives", 9'(sk_if.lives), 9'd0);
        check_flags("R.async", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Game D: scoring pattern, bonus thresholds and saturation
        do_start();
        do_ship();
        do_ticks(120);
        check("D.lives2", 9'(sk_if.lives), 9'd2);
        do_hit(2'b00); check("D.large",    9'(sk_if.score), 9'd1);
        do_hit(2'b01); check("D.med",      9'(sk_if.score), 9'd3);
        do_hit(2'b10); check("D.small",    9'(sk_if.score), 9'd8);
        do_hit(2'b11); check("D.reserved", 9'(sk_if.score), 9'd8);
        do_smalls(8);
        check("D.score48", 9'(sk_if.score), 9'd48);
        check("D.lives48", 9'(sk_if.lives), 9'd2);
        do_hit(2'b10);
        check("D.score53", 9'(sk_if.score), 9'd53);
        check("D.bonus50", 9'(sk_if.lives), BON ? 9'd3 : 9'd2);
        do_smalls(9);
        check("D.score98", 9'(sk_if.score), 9'd98);
        check("D.lives98", 9'(sk_if.lives), BON ? 9'd3 : 9'd2);
        do_ship();
        check("D.ship.lives", 9'(sk_if.lives), BON ? 9'd2 : 9'd1);
        check_flags("D.ship", 1'b0, 1'b1, 1'b0);
        do_ticks(120);
        do_hit(2'b10);
        check("D.score103", 9'(sk_if.score), 9'd103);
        check("D.bonus100", 9'(sk_if.lives), BON ? 9'd3 : 9'd1);
        do_smalls(30);
        check("D.score253", 9'(sk_if.score), 9'd253);
        do_hit(2'b10);
        check("D.sat1", 9'(sk_if.score), 9'd255);
        do_hit(2'b10);
        check("D.sat2", 9'(sk_if.score), 9'd255);
        do_hit(2'b00);
        check("D.sat3", 9'(sk_if.score), 9'd255);
        check("D.lives.end", 9'(sk_if.lives), BON ? 9'd3 : 9'd1);
        check_flags("D.end", 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
